// File: rtl/hyperbus_responder.sv
// HyperBus-style memory responder: 48-bit CA capture, fixed read/write latency,
// 2**AW x 16 array, read-only ID0 and writable CR0 configuration register.
module hyperbus_responder #(
  parameter int          LATENCY = 6,
  parameter int          AW      = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  input  logic        rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CA     = 3'd1;
  localparam logic [2:0] S_LAT    = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_REGW   = 3'd5;
  localparam logic [2:0] S_WAITCS = 3'd6;

  localparam int LW = $clog2(LATENCY + 1) + 1;

  logic [2:0]    state;
  logic [47:0]   ca;
  logic [47:0]   ca_next;
  logic [1:0]    ca_cnt;
  logic [LW-1:0] lat_cnt;
  logic [AW-1:0] addr;
  logic          is_rd;
  logic          is_reg;
  logic [15:0]   cr0;
  logic [15:0]   rd_val;
  logic          wr_en;
  logic [15:0]   mem [0:2**AW-1];

  // Only the low 32 bits are shifted onward; the top word is consumed via ca_next.
  logic unused_ca_hi;
  assign unused_ca_hi = ^ca[47:32];

  function automatic logic [AW-1:0] ca_addr(input logic [47:0] c);
    return {c[16+AW/2-1:16], c[AW-AW/2-1:0]};
  endfunction

  assign ca_next = {ca[31:0], dq_in};
  assign busy    = (state != S_IDLE);
  assign wr_en   = (state == S_WDATA) && !csn && ck_en && !rwds_in && !rst;

  // Register reads hold their captured address so the same value repeats.
  always_comb begin
    rd_val = mem[addr];
    if (is_reg) rd_val = (addr == '0) ? ID0_VAL : cr0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= dq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ca       <= '0;
      ca_cnt   <= '0;
      lat_cnt  <= '0;
      addr     <= '0;
      is_rd    <= 1'b0;
      is_reg   <= 1'b0;
      cr0      <= CR0_RST;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= 1'b0;
      rwds_oe  <= 1'b0;
    end else if (state != S_IDLE && csn) begin
      state    <= S_IDLE;
      ca       <= '0;
      ca_cnt   <= '0;
      lat_cnt  <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= 1'b0;
      rwds_oe  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!csn) begin
            state    <= S_CA;
            rwds_oe  <= 1'b1;
            rwds_out <= 1'b1;
          end
        end
        S_CA: begin
          if (ck_en) begin
            ca     <= ca_next;
            ca_cnt <= ca_cnt + 2'd1;
            if (ca_cnt == 2'd2) begin
              ca_cnt   <= '0;
              rwds_oe  <= 1'b0;
              rwds_out <= 1'b0;
              is_rd    <= ca_next[47];
              is_reg   <= ca_next[46];
              addr     <= ca_addr(ca_next);
              lat_cnt  <= '0;
              state    <= (ca_next[46] && !ca_next[47]) ? S_REGW : S_LAT;
            end
          end
        end
        S_LAT: begin
          if (lat_cnt == LW'(LATENCY)) begin
            if (is_rd) begin
              state    <= S_RDATA;
              dq_out   <= rd_val;
              dq_oe    <= 1'b1;
              rwds_oe  <= 1'b1;
              rwds_out <= 1'b1;
              if (!is_reg) addr <= addr + 1'b1;
            end else begin
              state <= S_WDATA;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_RDATA: begin
          if (ck_en) begin
            dq_out   <= rd_val;
            rwds_out <= 1'b1;
            if (!is_reg) addr <= addr + 1'b1;
          end else begin
            rwds_out <= 1'b0;
          end
        end
        S_WDATA: begin
          if (ck_en) addr <= addr + 1'b1;
        end
        S_REGW: begin
          if (ck_en) begin
            cr0   <= dq_in;
            state <= S_WAITCS;
          end
        end
        S_WAITCS: state <= S_WAITCS;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hyperbus_responder.md
HYPERBUS_RESPONDER -- requirements
Module: hyperbus_responder

Interface
REQ-001 Parameter LATENCY, default 6, clk cycles from the last CA word to the first memory data word.
REQ-002 Parameter AW, default 6, word-address width; array depth 2**AW x 16 bits.
REQ-003 Parameter ID0_VAL, default 16'h0C81, read-only identification register value.
REQ-004 Parameter CR0_RST, default 16'h8F1F, configuration register reset value.
REQ-005 Clock and reset are fixed: clk, rising-edge; rst, synchronous, active-high.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csn  in  1  host chip select, active-low
- ck_en  in  1  host bus-clock enable; a word transfers only when this is 1
- dq_in  in  16  host-driven data/CA word
- rwds_in  in  1  host write mask; 1 masks the current write word
- dq_out  out  16  responder read data
- dq_oe  out  1  responder drives dq
- rwds_out  out  1  ready during CA; read strobe in RDATA
- rwds_oe  out  1  responder drives rwds
- busy  out  1  transaction in progress (state != IDLE)

Function
REQ-007 States are IDLE, CA, LAT, RDATA, WDATA, REGW and WAITCS.
REQ-008 IDLE: when csn=0, next state is CA; rwds_oe and rwds_out are 1 from the next cycle until CA exits.
REQ-009 CA: on each cycle with ck_en=1, dq_in shifts into the 48-bit ca register, MSW first; the third captured word completes CA.
REQ-010 CA decode:
- bit47 is R/W# (1 = read).
- bit46 is the address space (1 = register).
- word address = {ca[16+AW/2-1:16], ca[AW-AW/2-1:0]}; AW=6 gives {ca[18:16], ca[2:0]}.
REQ-011 Transitions on CA completion:
- memory read or write goes to LAT;
- register read goes to LAT;
- register write goes to REGW;
- rwds_oe drops to 0 in the same cycle.
REQ-012 LAT: counts LATENCY clk cycles, not gated by ck_en, then enters RDATA on a read or WDATA on a write.
REQ-013 RDATA drive:
- the first word appears on dq_out exactly LATENCY+1 cycles after the cycle that captured CA word 3;
- dq_oe=1, rwds_oe=1, and rwds_out=1 on every cycle that presents a valid word.
REQ-014 RDATA advance: on each cycle with ck_en=1, the next word is presented with registered array read data and the address increments; with ck_en=0, the word holds and rwds_out=0.
REQ-015 Register read: address word 0 returns ID0_VAL; any other address returns CR0; the value is repeated while the burst continues.
REQ-016 WDATA: on each cycle with ck_en=1, mem[addr] <= dq_in unless rwds_in=1 (masked), and the address increments in both cases.
REQ-017 REGW: the first word with ck_en=1 is written to CR0 with no latency and no mask; the state then goes to WAITCS.
REQ-018 Address wraps from 2**AW-1 to 0 for both reads and writes.
REQ-019 csn=1 in any non-IDLE state returns the block to IDLE next cycle:
- dq_oe=0 and rwds_oe=0 on that same next cycle;
- the CA shift register and latency counter clear;
- a partial CA is discarded with no side effect.
REQ-020 WAITCS: no writes, dq_oe=0, rwds_oe=0; the block waits for csn=1.
REQ-021 csn=1 and ck_en=1 in the same cycle: csn wins and no transfer occurs.
REQ-022 busy=1 whenever state != IDLE.

Reset
REQ-023 Output reset values: dq_out=0, dq_oe=0, rwds_out=0, rwds_oe=0, busy=0.
REQ-024 Internal reset values: state=IDLE, CR0=CR0_RST, counters and ca register = 0.
REQ-025 rst dominates csn; asserting rst mid-transaction returns the block to IDLE next cycle with all outputs at reset values.
REQ-026 Array contents are not reset.

Verification
REQ-027 Write then read:
- stimulus: write CA 0x0000_0000_0003, then 4 words A1..A4 with ck_en=1, then csn=1; read CA 0x8000_0000_0003;
- response: dq_out = A1..A4 with rwds_out=1, the first word 7 cycles after CA word 3.
REQ-028 Write mask:
- stimulus: 3-word write at address 5 with rwds_in=0,1,0 on word 2, over preloaded 0xFFFF;
- response: readback = W1, 0xFFFF, W3.
REQ-029 Wrap:
- stimulus: write 3 words starting at address 63 (AW=6);
- response: the words land at addresses 63, 0, 1.
REQ-030 Register access:
- stimulus: register read at address 0, then register write 0x1234, then register read at address 1;
- response: 0x0C81, then 0x1234.
REQ-031 Abort:
- stimulus: csn=1 after CA word 2, or after read word 1;
- response: busy=0, dq_oe=0 and rwds_oe=0 next cycle; the next full transaction behaves normally.
REQ-032 Reset:
- stimulus: rst=1 during WDATA word 2;
- response: all outputs at reset values next cycle, CR0=0x8F1F, and word 1 retained in the array.
